// File: rtl/our_f_spsram_pipe.sv
// Parametrised single-port SRAM model with active-low CEN/WEN macro interface,
// pipelined read data with valid strobe, out-of-range flagging and trace port.

module our_f_spsram_pipe_lane (
   input  logic       en,
   input  logic [7:0] old_b,
   input  logic [7:0] new_b,
   output logic [7:0] strb,
   output logic [7:0] mrg
);
   assign strb = {8{en}};
   assign mrg  = en ? new_b : old_b;
endmodule

module our_f_spsram_pipe #(
   parameter int ADDR_WIDTH   = 21,
   parameter int DATA_WIDTH   = 128,
   parameter int DEPTH        = 1 << ADDR_WIDTH,
   parameter int READ_LATENCY = 1,
   parameter bit WRITE_FIRST  = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   A,
   input  logic                    CEN,
   input  logic [DATA_WIDTH-1:0]   D,
   input  logic [DATA_WIDTH/8-1:0] WEN,
   output logic [DATA_WIDTH-1:0]   Q,
   output logic                    q_valid_o,
   output logic                    err_o,
   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH-1:0]   mem_strb_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH-1:0]   mem_rdata_o
);
   localparam int NB     = DATA_WIDTH / 8;
   localparam int STAGES = READ_LATENCY;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 1024) begin : g_bad_dw
      $fatal(1, "our_f_spsram_pipe: DATA_WIDTH must be a multiple of 8 in 8..1024");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $fatal(1, "our_f_spsram_pipe: READ_LATENCY must be in 1..4");
   end
   if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
      $fatal(1, "our_f_spsram_pipe: DEPTH must be in 1..2^ADDR_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] mask, old_w, merged, res_d;
   logic [ADDR_WIDTH-1:0] hold;
   logic [IDX_W-1:0]      idx;
   logic                  in_rng, acc;

   logic [STAGES:0]                    vld_pipe;
   logic [STAGES:0]                    err_pipe;
   logic [STAGES-1:0][DATA_WIDTH-1:0]  dat_pipe;

   assign in_rng = {1'b0, A} < DEPTH_L;
   assign idx    = A[IDX_W-1:0];
   assign acc    = ~CEN & ~rst_i;
   assign old_w  = mem[idx];

   for (genvar b = 0; b < NB; b++) begin : g_lane
      our_f_spsram_pipe_lane u_lane (
         .en    (~CEN & ~WEN[b]),
         .old_b (old_w[b*8 +: 8]),
         .new_b (D[b*8 +: 8]),
         .strb  (mask[b*8 +: 8]),
         .mrg   (merged[b*8 +: 8])
      );
   end

   // out-of-range results carry zero data regardless of read-during-write mode
   assign res_d = in_rng ? (WRITE_FIRST ? merged : old_w) : '0;

   // merged already keeps unmasked bytes, so a whole-word store is a masked write
   always_ff @(posedge clk_i) begin
      if (acc && in_rng) mem[idx] <= merged;
   end

   // vld_pipe[STAGES] / err_pipe[STAGES] are the output strobes themselves
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe <= '0;
         err_pipe <= '0;
         Q        <= '0;
         hold     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], acc};
         err_pipe <= {err_pipe[STAGES-1:0], acc & ~in_rng};
         if (vld_pipe[STAGES-1]) Q <= dat_pipe[STAGES-1];
         if (!CEN) hold <= A;
      end
      dat_pipe[0] <= res_d;
      for (int k = STAGES - 1; k > 0; k--) dat_pipe[k] <= dat_pipe[k-1];
   end

   assign q_valid_o   = vld_pipe[STAGES];
   assign err_o       = err_pipe[STAGES];
   assign mem_req_o   = ~CEN;
   assign mem_addr_o  = CEN ? hold : A;
   assign mem_wdata_o = D;
   assign mem_strb_o  = mask;
   assign mem_we_o    = |mask;
   assign mem_rdata_o = Q;
endmodule

// File: tb/tb_our_f_spsram_pipe.sv
// Bench for our_f_spsram_pipe: four instances (latency 1..4, alternating
// read-first/write-first) share one stimulus stream; a scoreboard predicts results.

module tb_our_f_spsram_pipe;
   localparam int AW = 11, DW = 128, NB = DW / 8, DEPTH = 1024, NDUT = 4, NV = 29;
   localparam logic [NB-1:0] WALL = '0, WRD = '1;
   localparam logic [DW-1:0] ONES = '1;

   typedef struct {
      logic          rst, cen;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NB-1:0] wen;
      logic [AW-1:0] e_addr;
      logic          e_we;
      logic [DW-1:0] e_strb;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, cen;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic [NB-1:0] wen;

   logic [DW-1:0] q [NDUT], wd [NDUT], strb [NDUT], rd [NDUT];
   logic [AW-1:0] maddr [NDUT];
   logic          qv [NDUT], er [NDUT], req [NDUT], we [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      our_f_spsram_pipe #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
         .READ_LATENCY(g + 1), .WRITE_FIRST(1'(g % 2))
      ) u_dut (
         .clk_i(clk), .rst_i(rst), .A(a), .CEN(cen), .D(d), .WEN(wen),
         .Q(q[g]), .q_valid_o(qv[g]), .err_o(er[g]),
         .mem_req_o(req[g]), .mem_addr_o(maddr[g]), .mem_wdata_o(wd[g]),
         .mem_strb_o(strb[g]), .mem_we_o(we[g]), .mem_rdata_o(rd[g])
      );
   end

   int n_vec = 0, n_bad = 0;

   task automatic chk(input string nm, input int idx, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[dut%0d] @%0t: got %h, want %h", nm, idx, $time, act, exp);
      end
   endtask

   // scoreboard: one entry per accepted access, consumed in order by each DUT
   logic [DW-1:0] mdl [DEPTH];
   int            sb_cyc [256];
   logic [DW-1:0] sb_rf [256], sb_wf [256];
   logic          sb_err [256];
   int            wr_ptr = 0, cyc = 0;
   int            rd_idx [NDUT];
   logic [DW-1:0] exp_q [NDUT];

   initial begin : mon
      logic          ev, ee, oor;
      logic [DW-1:0] msk, old, mrg;
      for (int i = 0; i < NDUT; i++) begin rd_idx[i] = 0; exp_q[i] = '0; end
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NDUT; i++) begin
            ev = 1'b0;
            ee = 1'b0;
            if (rst) begin
               rd_idx[i] = wr_ptr;
               exp_q[i]  = '0;
            end else if (rd_idx[i] < wr_ptr && sb_cyc[rd_idx[i]] + i + 1 == cyc) begin
               ev       = 1'b1;
               ee       = sb_err[rd_idx[i]];
               exp_q[i] = (i % 2 == 1) ? sb_wf[rd_idx[i]] : sb_rf[rd_idx[i]];
               rd_idx[i]++;
            end
            chk("q_valid", i, DW'(qv[i]), DW'(ev));
            chk("err", i, DW'(er[i]), DW'(ee));
            chk("Q", i, q[i], exp_q[i]);
            chk("mem_rdata", i, rd[i], exp_q[i]);
         end
         if (!rst && !cen) begin
            for (int b = 0; b < NB; b++) msk[b*8 +: 8] = {8{~wen[b]}};
            oor = int'(a) >= DEPTH;
            old = oor ? '0 : mdl[a[9:0]];
            mrg = (old & ~msk) | (d & msk);
            sb_cyc[wr_ptr] = cyc;
            sb_rf[wr_ptr]  = old;
            sb_wf[wr_ptr]  = oor ? '0 : mrg;
            sb_err[wr_ptr] = oor;
            if (!oor) mdl[a[9:0]] = mrg;
            wr_ptr++;
         end
      end
   end

   function automatic vec_t mk(input logic r, input logic c, input logic [AW-1:0] ad,
                               input logic [DW-1:0] dd, input logic [NB-1:0] w,
                               input logic [AW-1:0] ea, input logic ew,
                               input logic [DW-1:0] es);
      vec_t v;
      v.rst = r; v.cen = c; v.a = ad; v.d = dd; v.wen = w;
      v.e_addr = ea; v.e_we = ew; v.e_strb = es;
      return v;
   endfunction

   function automatic logic [DW-1:0] dpat(input int k);
      return {4{32'(32'h0101_0101 * (k + 1))}};
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      rst = v.rst; cen = v.cen; a = v.a; d = v.d; wen = v.wen;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk("mem_req", i, DW'(req[i]), DW'(!v.cen));
         chk("mem_addr", i, DW'(maddr[i]), DW'(v.e_addr));
         chk("mem_we", i, DW'(we[i]), DW'(v.e_we));
         chk("mem_strb", i, strb[i], v.e_strb);
         chk("mem_wdata", i, wd[i], v.d);
      end
   endtask

   vec_t tbl [NV];
   logic [DW-1:0] AAAA, H5555, DEAD, CAFE;

   initial begin
      AAAA  = {16{8'hAA}};
      H5555 = {16{8'h55}};
      DEAD  = {8{16'hDEAD}};
      CAFE  = {4{32'hCAFE_F00D}};
      rst = 1'b1; cen = 1'b1; a = '0; d = '0; wen = WRD;

      tbl[0] = mk(1, 1, 0, 0, WRD, 0, 0, 0);
      tbl[1] = mk(1, 0, 7, ONES, WALL, 7, 1, ONES);
      tbl[2] = mk(0, 1, 0, 0, WRD, 0, 0, 0);
      for (int k = 0; k < 4; k++) tbl[3+k] = mk(0, 0, AW'(k), dpat(k), WALL, AW'(k), 1, ONES);
      tbl[7]  = mk(0, 0, 'h10, ONES, WALL, 'h10, 1, ONES);
      tbl[8]  = mk(0, 0, 'h10, 0, 16'hFFF0, 'h10, 1, {96'h0, 32'hFFFF_FFFF});
      tbl[9]  = mk(0, 0, 'h10, 0, WRD, 'h10, 0, 0);
      tbl[10] = mk(0, 0, 5, AAAA, WALL, 5, 1, ONES);
      tbl[11] = mk(0, 0, 5, H5555, WALL, 5, 1, ONES);
      tbl[12] = mk(0, 0, 5, 0, WRD, 5, 0, 0);
      for (int k = 0; k < 4; k++) tbl[13+k] = mk(0, 0, AW'(k), 0, WRD, AW'(k), 0, 0);
      for (int k = 17; k < 20; k++) tbl[k] = mk(0, 1, 0, 0, WRD, 3, 0, 0);
      tbl[20] = mk(0, 0, 11'd1024, DEAD, WALL, 11'd1024, 1, ONES);
      tbl[21] = mk(0, 0, 11'd1024, 0, WRD, 11'd1024, 0, 0);
      tbl[22] = mk(0, 0, 0, 0, WRD, 0, 0, 0);
      tbl[23] = mk(0, 0, 11'd1023, CAFE, WALL, 11'd1023, 1, ONES);
      tbl[24] = mk(0, 0, 11'd1023, 0, WRD, 11'd1023, 0, 0);
      for (int k = 25; k < NV; k++) tbl[k] = mk(0, 1, 0, 0, WRD, 11'd1023, 0, 0);

      repeat (2) @(posedge clk);
      for (int k = 0; k < NV; k++) apply(tbl[k]);

      // reset landing on in-flight reads, with a write presented during reset
      apply(mk(0, 0, 0, 0, WRD, 0, 0, 0));
      apply(mk(0, 0, 1, 0, WRD, 1, 0, 0));
      apply(mk(1, 0, 0, {4{32'hBAD0_BAD0}}, WALL, 0, 1, ONES));
      for (int k = 0; k < 6; k++) apply(mk(0, 1, 0, 0, WRD, 0, 0, 0));
      apply(mk(0, 0, 0, 0, WRD, 0, 0, 0));
      for (int k = 0; k < 8; k++) apply(mk(0, 1, 0, 0, WRD, 0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk("drained", i, DW'(rd_idx[i]), DW'(wr_ptr));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/our_f_spsram_pipe.md
Name: our_f_spsram_pipe

Overview:
- Parametrised single-port SRAM model for the OpenC910 simulation memory subsystem; successor to the fixed 128-bit large SPSRAM wrapper.
- Keeps the legacy active-low CEN/WEN macro interface and exposes a trace/DPI monitor port.
- Adds:
  - configurable data width and depth
  - configurable read latency through an output pipeline with a valid strobe
  - selectable read-during-write mode
  - out-of-range access detection
- Sits behind the L2/SoC memory adapter, replacing the bank-of-RAMs macros.

Parameters:
- ADDR_WIDTH, 21, word-address width.
- DATA_WIDTH, 128, data width in bits; must be a multiple of 8, range 8..1024.
- DEPTH, 1<<ADDR_WIDTH, number of implemented words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted access to Q/q_valid_o; legal range 1..4.
- WRITE_FIRST, 0:
  - 0 = read-first: a write access returns the old word.
  - 1 = write-first: a write access returns the merged new word.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- A  in  ADDR_WIDTH  word address.
- CEN  in  1  chip enable, active low.
- D  in  DATA_WIDTH  write data.
- WEN  in  DATA_WIDTH/8  per-byte write enable, active low.
- Q  out  DATA_WIDTH  read data.
- q_valid_o  out  1  Q updated this cycle.
- err_o  out  1  one-cycle pulse, aligned with q_valid_o, for an out-of-range access.
- mem_req_o  out  1  trace: access accepted (= ~CEN).
- mem_addr_o  out  ADDR_WIDTH  trace: effective address.
- mem_wdata_o  out  DATA_WIDTH  trace: D.
- mem_strb_o  out  DATA_WIDTH  trace: bitwise write mask.
- mem_we_o  out  1  trace: any byte written.
- mem_rdata_o  out  DATA_WIDTH  trace: equals Q.

Behaviour:
- Clock/reset: one clock domain, clk_i; rst_i is synchronous and active-high.
- Access acceptance: an access is accepted on a rising edge when CEN=0 and rst_i=0. No backpressure; one access per cycle sustained.
- Byte mask: byte i is written iff CEN=0 and WEN[i]=0. The bit mask replicates each byte enable 8×.
  - mem_we_o = OR of the mask.
  - All WEN bits high = pure read.
- Address hold: a hold register captures A on every accepted access.
  - mem_addr_o = A when CEN=0, else the held address.
  - Trace outputs are combinational from the inputs and the hold register; mem_req_o=0 whenever CEN=1.
- Storage: a behavioural array of DEPTH words.
  - A write updates only the masked bits, at the accepting edge.
  - Array contents are not reset; unwritten words read X in simulation.
- Read result (every accepted access, read or write, produces exactly one result):
  - WRITE_FIRST=0: word before this cycle's write.
  - WRITE_FIRST=1: (old & ~mask) | (D & mask).
- Pipeline: READ_LATENCY stages, each holding a valid bit, data, and an err bit.
  - A result accepted at edge N appears at edge N+READ_LATENCY-1+1, i.e. visible READ_LATENCY cycles after acceptance.
  - q_valid_o is high for exactly one cycle per result.
  - Back-to-back accesses give back-to-back results, in order.
- Q hold: Q updates only when a valid result leaves the last stage; otherwise it holds the last delivered value.
- Out-of-range (A ≥ DEPTH):
  - The write is dropped with no array change.
  - The result data is all zeros, err_o=1 with that result's q_valid_o.
  - The hold register still captures A.
- Reset, while rst_i=1:
  - All pipeline valid bits cleared; in-flight results discarded and never delivered.
  - Q=0, q_valid_o=0, err_o=0, hold address=0.
  - An access presented with CEN=0 in the same cycle as rst_i=1 is ignored: no write, no result.
  - Trace outputs still mirror the inputs combinationally.
  - First accepted access is on the first edge with rst_i=0.
- Same-address back-to-back write then read: the read returns the just-written data. The array is updated at the write edge, with no hazard.
- Elaboration-time checks: fatal assertion if DATA_WIDTH%8≠0, READ_LATENCY outside 1..4, or DEPTH > 2^ADDR_WIDTH.

Test Plan:
1. Reset/idle: defaults, READ_LATENCY=2; hold rst_i 3 cycles then release with CEN=1 → Q=0, q_valid_o=0, err_o=0, mem_req_o=0, mem_addr_o=0.
2. Masked write + read, READ_LATENCY=2:
   - Stimulus: write A=0x10, D=all 0xFF, WEN=all 0; next cycle write A=0x10, D=0, WEN=0xFFF0; next cycle read A=0x10.
   - Response: the read result has the low 4 bytes 0x00 and the rest 0xFF. Its q_valid_o is high exactly 2 cycles after the read is accepted. mem_strb_o during the 2nd write = 0x...FFFFFFFF in the low 32 bits only.
3. Read-during-write mode:
   - Stimulus: word 0x5 initialised to 0xAAAA…; write 0x5555… with full mask.
   - Response: returned result = 0xAAAA… with WRITE_FIRST=0, 0x5555… with WRITE_FIRST=1.
4. Streaming/hold, READ_LATENCY=3: reads of 0x0,0x1,0x2,0x3 on consecutive cycles, then CEN=1 →
   - 4 consecutive q_valid_o pulses, in order.
   - Q holds word 0x3 afterward; mem_addr_o holds 0x3 while CEN=1.
5. Out-of-range, DEPTH=1024:
   - Stimulus: write 0xDEAD… to A=1024, then read A=1024 and A=0.
   - Response: err_o pulses with the first two results, data=0; word 0 unchanged.
6. Reset mid-operation, READ_LATENCY=4: issue 2 reads, assert rst_i one cycle later for 1 cycle with CEN=0 → no q_valid_o for either read, no write performed, Q=0.
